// File: rtl/hazard_detection_unit.sv
// ============================================================================
// hazard_detection_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Load-use hazard detector for a classic five-stage pipeline. When the
//   instruction in EX is a load, and it writes a register that the
//   instruction in decode reads, the decode instruction would pick up a
//   stale value. In that case this unit holds the PC and the IF/ID register
//   for one cycle and injects a bubble into ID/EX. Register x0 is hard-wired
//   to zero, so a load that targets x0 never creates a hazard.
//
//   The unit also keeps a registered copy of the stall request and a
//   saturating count of stalled cycles, which can be used for performance
//   monitoring.
//
// Parameters:
//   REG_AW        register-address width (5 for a 32-entry register file)
//   CNT_W         width of the stall-cycle counter
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           synchronous, active-high reset (registered state only)
//   DMRd_ex       instruction in EX reads data memory (is a load)
//   rs1_de        source register 1 of the instruction in decode
//   rs2_de        source register 2 of the instruction in decode
//   rd_ex         destination register of the instruction in EX
//   HDUStall      combinational load-use hazard / stall request
//   PCWrite_en    PC write enable (low while stalling)
//   IFID_Write_en IF/ID pipeline-register write enable (low while stalling)
//   IDEX_Flush    zero the control fields entering ID/EX (high while stalling)
//   HDUStall_q    HDUStall delayed by one clock
//   stall_count   number of clock edges at which HDUStall was high,
//                 saturating at its all-ones value
// ============================================================================
module hazard_detection_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DMRd_ex,
    input  logic [REG_AW-1:0] rs1_de,
    input  logic [REG_AW-1:0] rs2_de,
    input  logic [REG_AW-1:0] rd_ex,
    output logic              HDUStall,
    output logic              PCWrite_en,
    output logic              IFID_Write_en,
    output logic              IDEX_Flush,
    output logic              HDUStall_q,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic rs1_match;
    logic rs2_match;
    logic rd_is_real;
    logic hazard;

    // Hazard detection is purely combinational so the stall takes effect in
    // the same cycle the load sits in EX. Reset deliberately does not gate
    // it: the pipeline-control outputs always reflect the current operands.
    // Both sources are compared in full-width equality; a match on either
    // one is enough, since the decode instruction reads both.
    always_comb begin
        rs1_match  = (rd_ex == rs1_de);
        rs2_match  = (rd_ex == rs2_de);
        rd_is_real = (rd_ex != REG_ZERO);
        hazard     = DMRd_ex & rd_is_real & (rs1_match | rs2_match);
    end

    // A stall freezes the front end (PC and IF/ID) and turns the slot
    // entering EX into a bubble; all three follow the hazard directly.
    assign HDUStall      = hazard;
    assign PCWrite_en    = ~hazard;
    assign IFID_Write_en = ~hazard;
    assign IDEX_Flush    = hazard;

    // One-cycle delayed copy of the stall request, for consumers that need
    // to know the previous cycle was a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            HDUStall_q <= 1'b0;
        end else begin
            HDUStall_q <= hazard;
        end
    end

    // Stall-cycle counter. It sticks at all-ones instead of wrapping so a
    // long run never reads back as a small number. Reset has priority over
    // a coincident stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// ============================================================================
// tb_hazard_detection_unit
// ----------------------------------------------------------------------------
// Drives two instances from the same inputs: one with the default 32-bit
// counter and one with a 2-bit counter so saturation is reachable quickly.
// Expected values come from a reference model written directly from the
// load-use rule: a load in EX that writes a non-zero register read by the
// decode instruction forces a stall; stall cycles are counted up to the
// counter's maximum.
// ============================================================================
module tb_hazard_detection_unit;

    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              DMRd_ex;
    logic [REG_AW-1:0] rs1_de;
    logic [REG_AW-1:0] rs2_de;
    logic [REG_AW-1:0] rd_ex;

    logic              HDUStall;
    logic              PCWrite_en;
    logic              IFID_Write_en;
    logic              IDEX_Flush;
    logic              HDUStall_q;
    logic [31:0]       stall_count;

    logic              s_HDUStall;
    logic              s_PCWrite_en;
    logic              s_IFID_Write_en;
    logic              s_IDEX_Flush;
    logic              s_HDUStall_q;
    logic [1:0]        s_stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit      m_stall;
    bit      m_stall_q;
    longint  m_count;
    int      m_count_small;

    hazard_detection_unit #(.REG_AW(REG_AW), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .DMRd_ex      (DMRd_ex),
        .rs1_de       (rs1_de),
        .rs2_de       (rs2_de),
        .rd_ex        (rd_ex),
        .HDUStall     (HDUStall),
        .PCWrite_en   (PCWrite_en),
        .IFID_Write_en(IFID_Write_en),
        .IDEX_Flush   (IDEX_Flush),
        .HDUStall_q   (HDUStall_q),
        .stall_count  (stall_count)
    );

    hazard_detection_unit #(.REG_AW(REG_AW), .CNT_W(2)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .DMRd_ex      (DMRd_ex),
        .rs1_de       (rs1_de),
        .rs2_de       (rs2_de),
        .rd_ex        (rd_ex),
        .HDUStall     (s_HDUStall),
        .PCWrite_en   (s_PCWrite_en),
        .IFID_Write_en(s_IFID_Write_en),
        .IDEX_Flush   (s_IDEX_Flush),
        .HDUStall_q   (s_HDUStall_q),
        .stall_count  (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load-use rule: the decode instruction's source list is scanned for the
    // load's destination; x0 is never a real destination.
    function automatic bit model_stall(bit ld, int s1, int s2, int d);
        int srcs[2];
        srcs[0] = s1;
        srcs[1] = s2;
        if (!ld || d == 0) return 1'b0;
        foreach (srcs[i]) if (srcs[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a new operand set mid-cycle, away from the active edge.
    task automatic applyStimulus(input bit r, input bit ld, input int s1,
                                 input int s2, input int d);
        @(negedge clk);
        rst     = r;
        DMRd_ex = ld;
        rs1_de  = REG_AW'(s1);
        rs2_de  = REG_AW'(s2);
        rd_ex   = REG_AW'(d);
        m_stall = model_stall(ld, s1, s2, d);
        #1;
    endtask

    // Check the combinational outputs, take one clock edge, advance the
    // model, then check the registered outputs just after the edge.
    task automatic checkOutput();
        chk("HDUStall",        HDUStall,          m_stall);
        chk("PCWrite_en",      PCWrite_en,        !m_stall);
        chk("IFID_Write_en",   IFID_Write_en,     !m_stall);
        chk("IDEX_Flush",      IDEX_Flush,        m_stall);
        chk("small_HDUStall",  s_HDUStall,        m_stall);
        @(posedge clk);
        if (rst) begin
            m_stall_q     = 1'b0;
            m_count       = 0;
            m_count_small = 0;
        end else begin
            m_stall_q = m_stall;
            if (m_stall) begin
                if (m_count < 64'hFFFF_FFFF) m_count++;
                if (m_count_small < 3) m_count_small++;
            end
        end
        #1;
        chk("HDUStall_q",        HDUStall_q,    m_stall_q);
        chk("stall_count",       stall_count,   m_count);
        chk("small_HDUStall_q",  s_HDUStall_q,  m_stall_q);
        chk("small_stall_count", s_stall_count, m_count_small);
    endtask

    task automatic step(input bit r, input bit ld, input int s1,
                        input int s2, input int d);
        applyStimulus(r, ld, s1, s2, d);
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; DMRd_ex = 1'b0; rs1_de = '0; rs2_de = '0; rd_ex = '0;
        m_stall = 0; m_stall_q = 0; m_count = 0; m_count_small = 0;

        // Reset for two edges; the second has a hazard present, which must
        // still show combinationally but must not be counted.
        step(1, 0, 2, 4, 4);
        step(1, 1, 2, 4, 2);
        chk("reset_count", stall_count, 0);

        // Three hazard cycles then one clean cycle.
        step(0, 1, 2, 4, 2);
        step(0, 1, 2, 4, 4);
        step(0, 1, 7, 7, 7);
        step(0, 0, 2, 4, 4);
        chk("three_stalls_count", stall_count, 3);
        chk("three_stalls_q",     HDUStall_q,  0);

        // Boundary operand patterns.
        step(0, 1, 2, 4, 8);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 5, 0);
        step(0, 1, 31, 30, 31);
        step(0, 1, 30, 31, 31);
        step(0, 0, 31, 31, 31);

        // Keep stalling until the 2-bit counter has clearly saturated.
        for (int i = 0; i < 5; i++) step(0, 1, 9, 3, 9);
        chk("small_saturated", s_stall_count, 3);

        // Reset coinciding with a hazard clears both counters.
        step(1, 1, 9, 3, 9);
        chk("reset_wins_small", s_stall_count, 0);
        chk("reset_wins_big",   stall_count,   0);

        // Randomized operands, biased toward a small register pool so that
        // matches, x0 destinations and saturation all occur often.
        for (int i = 0; i < 400; i++) begin
            bit r, ld;
            int s1, s2, d;
            r  = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                s1 = $urandom_range(0, 31);
                s2 = $urandom_range(0, 31);
                d  = $urandom_range(0, 31);
            end else begin
                s1 = $urandom_range(0, 3);
                s2 = $urandom_range(0, 3);
                d  = $urandom_range(0, 3);
            end
            step(r, ld, s1, s2, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: Hazard_Detection_Unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning the register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the stall-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port DMRd_ex, input, 1 bit: the instruction in EX reads data memory (load).
REQ-006 The block SHALL have port rs1_de, input, REG_AW bits: source register 1 of the instruction in decode.
REQ-007 The block SHALL have port rs2_de, input, REG_AW bits: source register 2 of the instruction in decode.
REQ-008 The block SHALL have port rd_ex, input, REG_AW bits: destination register of the instruction in EX.
REQ-009 The block SHALL have port HDUStall, output, 1 bit: load-use hazard detected, stall requested.
REQ-010 The block SHALL have port PCWrite_en, output, 1 bit: PC register write enable.
REQ-011 The block SHALL have port IFID_Write_en, output, 1 bit: IF/ID pipeline-register write enable.
REQ-012 The block SHALL have port IDEX_Flush, output, 1 bit: insert a bubble (zero control signals) into ID/EX.
REQ-013 The block SHALL have port HDUStall_q, output, 1 bit: HDUStall registered by one cycle.
REQ-014 The block SHALL have port stall_count, output, CNT_W bits: number of cycles in which HDUStall was 1.

Function
REQ-015 HDUStall SHALL be purely combinational: 1 iff DMRd_ex=1 AND rd_ex!=0 AND (rd_ex==rs1_de OR rd_ex==rs2_de).
REQ-016 HDUStall SHALL NOT depend on clk or rst; it SHALL settle within the same delta/cycle as its inputs change.
REQ-017 rd_ex=0 (x0) SHALL never cause a stall, even when a source register is also 0.
REQ-018 When DMRd_ex=0, HDUStall SHALL be 0 regardless of register matches.
REQ-019 A match on rs1_de alone, rs2_de alone, or both SHALL each produce HDUStall=1.
REQ-020 PCWrite_en and IFID_Write_en SHALL equal NOT HDUStall, combinationally.
REQ-021 IDEX_Flush SHALL equal HDUStall, combinationally.
REQ-022 HDUStall_q SHALL take the value of HDUStall at each rising clk edge when rst=0.
REQ-023 stall_count SHALL increment by 1 on each rising clk edge where rst=0 and HDUStall=1.
REQ-024 stall_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 Address comparison SHALL be full REG_AW-bit equality; the block SHALL treat X/Z as no match only in the sense of not adding extra logic.

Reset
REQ-026 While rst=1 at a rising clk edge, HDUStall_q SHALL become 0 and stall_count SHALL become 0.
REQ-027 Reset SHALL NOT gate the combinational outputs: HDUStall, PCWrite_en, IFID_Write_en and IDEX_Flush SHALL follow REQ-015/020/021 during reset.
REQ-028 If rst and a stall coincide at the same edge, the reset SHALL win: the counter SHALL be 0, not incremented.

Verification
REQ-029 DMRd_ex=0, rs1_de=2, rs2_de=4, rd_ex=4 -> HDUStall=0, PCWrite_en=1, IDEX_Flush=0.
REQ-030 DMRd_ex=1, rs1_de=2, rs2_de=4, rd_ex=2 -> HDUStall=1, PCWrite_en=0, IFID_Write_en=0, IDEX_Flush=1.
REQ-031 DMRd_ex=1, rs1_de=2, rs2_de=4, rd_ex=4 -> HDUStall=1; DMRd_ex=1, rs1_de=2, rs2_de=4, rd_ex=8 -> HDUStall=0.
REQ-032 DMRd_ex=1, rs1_de=0, rs2_de=0, rd_ex=0 -> HDUStall=0.
REQ-033 rst=1 for 2 edges, then 3 edges with a hazard and 1 without -> stall_count=3, HDUStall_q=0 after the final edge.
REQ-034 With CNT_W=2, 5 hazard cycles -> stall_count saturates at 3; then assert rst for 1 edge -> stall_count=0.
